// File: rtl/aurora_tx_arbiter.sv
// Two-source frame-atomic arbiter onto an Aurora user TX stream.
// Define TX_ARB_STATS_EN to build the sent/drop statistics counters.
module aurora_tx_arbiter #(
    parameter  int DATA_W = 32,
    parameter  int CNT_W  = 16,
    localparam int KEEP_W = DATA_W / 8
) (
    input  logic              io_clk,
    input  logic              reset_n,
    input  logic              channel_up,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic [KEEP_W-1:0] s0_tkeep,
    input  logic              s0_tlast,
    input  logic              s0_tvalid,
    output logic              s0_tready,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic [KEEP_W-1:0] s1_tkeep,
    input  logic              s1_tlast,
    input  logic              s1_tvalid,
    output logic              s1_tready,
    output logic [DATA_W-1:0] tx_data,
    output logic [KEEP_W-1:0] tx_tkeep,
    output logic              tx_tlast,
    output logic              tx_tvalid,
    input  logic              tx_tready,
    output logic [1:0]        grant,
    output logic              frame_drop,
    output logic [CNT_W-1:0]  sent0_cnt,
    output logic [CNT_W-1:0]  sent1_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1,
        FLUSH
    } state_t;

    state_t state_q, state_d;
    logic   last_owner_q, last_owner_d;
    logic   flush_src_q, flush_src_d;
    logic   drop_q, drop_d;

    logic              sel;
    logic [DATA_W-1:0] m_data;
    logic [KEEP_W-1:0] m_keep;
    logic              m_last;
    logic              m_valid;

    // Source currently owning the stream, or being drained after an abort.
    assign sel = (state_q == GRANT1) ||
                 ((state_q == FLUSH) && flush_src_q);

    assign m_data  = sel ? s1_tdata  : s0_tdata;
    assign m_keep  = sel ? s1_tkeep  : s0_tkeep;
    assign m_last  = sel ? s1_tlast  : s0_tlast;
    assign m_valid = sel ? s1_tvalid : s0_tvalid;

    always_ff @(posedge io_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            flush_src_q  <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            flush_src_q  <= flush_src_d;
            drop_q       <= drop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        flush_src_d  = flush_src_q;
        drop_d       = 1'b0;
        tx_data      = '0;
        tx_tkeep     = '0;
        tx_tlast     = 1'b0;
        tx_tvalid    = 1'b0;
        s0_tready    = 1'b0;
        s1_tready    = 1'b0;
        grant        = 2'b00;
        case (state_q)
            IDLE: begin
                if (channel_up) begin
                    if (s0_tvalid && s1_tvalid) begin
                        state_d = last_owner_q ? GRANT0 : GRANT1;
                    end else if (s0_tvalid) begin
                        state_d = GRANT0;
                    end else if (s1_tvalid) begin
                        state_d = GRANT1;
                    end
                end
            end
            GRANT0, GRANT1: begin
                tx_data   = m_data;
                tx_tkeep  = m_keep;
                tx_tlast  = m_last;
                tx_tvalid = m_valid;
                s0_tready = !sel && tx_tready;
                s1_tready = sel && tx_tready;
                grant     = sel ? 2'b10 : 2'b01;
                // A completing beat wins over a simultaneous link loss.
                if (m_valid && tx_tready && m_last) begin
                    state_d      = IDLE;
                    last_owner_d = sel;
                end else if (!channel_up) begin
                    state_d     = FLUSH;
                    flush_src_d = sel;
                    drop_d      = 1'b1;
                end
            end
            FLUSH: begin
                s0_tready = !sel;
                s1_tready = sel;
                if (m_valid && m_last) begin
                    state_d      = IDLE;
                    last_owner_d = sel;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign frame_drop = drop_q;

`ifdef TX_ARB_STATS_EN
    logic [CNT_W-1:0] sent0_q, sent1_q, dropc_q;
    logic             sent0_inc, sent1_inc;

    assign sent0_inc = (state_q == GRANT0) && s0_tvalid &&
                       tx_tready && s0_tlast;
    assign sent1_inc = (state_q == GRANT1) && s1_tvalid &&
                       tx_tready && s1_tlast;

    always_ff @(posedge io_clk or negedge reset_n) begin
        if (!reset_n) begin
            sent0_q <= '0;
            sent1_q <= '0;
            dropc_q <= '0;
        end else begin
            if (sent0_inc) sent0_q <= sent0_q + CNT_W'(1);
            if (sent1_inc) sent1_q <= sent1_q + CNT_W'(1);
            if (drop_d)    dropc_q <= dropc_q + CNT_W'(1);
        end
    end

    assign sent0_cnt = sent0_q;
    assign sent1_cnt = sent1_q;
    assign drop_cnt  = dropc_q;
`else
    assign sent0_cnt = '0;
    assign sent1_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Directed bench for aurora_tx_arbiter; counter expectations follow
// whether TX_ARB_STATS_EN is defined for the build.
module tb_aurora_tx_arbiter;

    localparam int DW = 32;
    localparam int KW = 4;
    localparam int CW = 16;
`ifdef TX_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          io_clk = 1'b0;
    logic          reset_n;
    logic          channel_up;
    logic [DW-1:0] s0_tdata, s1_tdata, tx_data;
    logic [KW-1:0] s0_tkeep, s1_tkeep, tx_tkeep;
    logic          s0_tlast, s0_tvalid, s0_tready;
    logic          s1_tlast, s1_tvalid, s1_tready;
    logic          tx_tlast, tx_tvalid, tx_tready;
    logic [1:0]    grant;
    logic          frame_drop;
    logic [CW-1:0] sent0_cnt, sent1_cnt, drop_cnt;

    aurora_tx_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .io_clk    (io_clk),
        .reset_n   (reset_n),
        .channel_up(channel_up),
        .s0_tdata  (s0_tdata),
        .s0_tkeep  (s0_tkeep),
        .s0_tlast  (s0_tlast),
        .s0_tvalid (s0_tvalid),
        .s0_tready (s0_tready),
        .s1_tdata  (s1_tdata),
        .s1_tkeep  (s1_tkeep),
        .s1_tlast  (s1_tlast),
        .s1_tvalid (s1_tvalid),
        .s1_tready (s1_tready),
        .tx_data   (tx_data),
        .tx_tkeep  (tx_tkeep),
        .tx_tlast  (tx_tlast),
        .tx_tvalid (tx_tvalid),
        .tx_tready (tx_tready),
        .grant     (grant),
        .frame_drop(frame_drop),
        .sent0_cnt (sent0_cnt),
        .sent1_cnt (sent1_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 io_clk = ~io_clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic [1:0]    g;
        int            cyc;
    } cap_t;

    beat_t q0[$];
    beat_t q1[$];
    cap_t  cap[$];
    logic  hs0 = 1'b0;
    logic  hs1 = 1'b0;
    int    cyc = 0;
    int    drops = 0;
    int    errors = 0;
    int    checks = 0;

    function automatic int ce(int v);
        return STATS ? v : 0;
    endfunction

    // Observe handshakes and TX transfers mid-cycle, away from the edge.
    always @(negedge io_clk) begin
        cyc = cyc + 1;
        hs0 = s0_tvalid && s0_tready;
        hs1 = s1_tvalid && s1_tready;
        if (tx_tvalid && tx_tready)
            cap.push_back('{d: tx_data, k: tx_tkeep, l: tx_tlast,
                            g: grant, cyc: cyc});
        if (frame_drop) drops = drops + 1;
    end

    // Source models: pop on handshake, present queue head after the edge.
    always @(posedge io_clk) begin
        #1;
        if (hs0 && q0.size() > 0) void'(q0.pop_front());
        if (hs1 && q1.size() > 0) void'(q1.pop_front());
        s0_tvalid = q0.size() > 0;
        s0_tdata  = s0_tvalid ? q0[0].d : '0;
        s0_tkeep  = s0_tvalid ? q0[0].k : '0;
        s0_tlast  = s0_tvalid ? q0[0].l : 1'b0;
        s1_tvalid = q1.size() > 0;
        s1_tdata  = s1_tvalid ? q1[0].d : '0;
        s1_tkeep  = s1_tvalid ? q1[0].k : '0;
        s1_tlast  = s1_tvalid ? q1[0].l : 1'b0;
    end

    task automatic tick();
        @(posedge io_clk);
        #2;
    endtask

    task automatic push0(logic [DW-1:0] base, int n, logic [KW-1:0] k);
        for (int i = 0; i < n; i++)
            q0.push_back('{d: base + DW'(i), k: k, l: (i == n - 1)});
    endtask

    task automatic push1(logic [DW-1:0] base, int n, logic [KW-1:0] k);
        for (int i = 0; i < n; i++)
            q1.push_back('{d: base + DW'(i), k: k, l: (i == n - 1)});
    endtask

    task automatic wait_cap(int n, int budget, string name);
        int t;
        t = 0;
        while (cap.size() < n && t < budget) begin
            tick();
            t++;
        end
        checks++;
        if (cap.size() < n) begin
            errors++;
            $display("FAIL %s timeout: beats=%0d want %0d",
                     name, cap.size(), n);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q0.delete();
        q1.delete();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        cap.delete();
        drops = 0;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({grant, tx_tvalid, s0_tready, s1_tready, frame_drop} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b want 000000",
                     {grant, tx_tvalid, s0_tready, s1_tready, frame_drop});
        end
        checks++;
        if ({sent0_cnt, sent1_cnt, drop_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_cnt: got %h %h %h want 0",
                     sent0_cnt, sent1_cnt, drop_cnt);
        end
        reset_n = 1'b1;
        tick();
        push0(32'h1111_0000, 1, 4'hF);
        repeat (4) begin
            tick();
            checks++;
            if (grant !== 2'b00 || s0_tready !== 1'b0) begin
                errors++;
                $display("FAIL link_down_idle: grant=%b rdy=%b want 00 0",
                         grant, s0_tready);
            end
        end
        q0.delete();
        tick();
    endtask

    task automatic test_single_frame();
        cap.delete();
        channel_up = 1'b1;
        tx_tready  = 1'b1;
        push0(32'hCAFE_BABE, 3, 4'hF);
        tick();
        checks++;
        if (grant !== 2'b00 || tx_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL sf_idle: grant=%b tvalid=%b want 00 0",
                     grant, tx_tvalid);
        end
        tick();
        checks++;
        if (grant !== 2'b01 || tx_data !== 32'hCAFE_BABE ||
            s0_tready !== 1'b1 || s1_tready !== 1'b0) begin
            errors++;
            $display("FAIL sf_grant: grant=%b data=%h want 01 cafebabe",
                     grant, tx_data);
        end
        wait_cap(3, 10, "sf_beats");
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL sf_back_idle: grant=%b want 00", grant);
        end
        for (int i = 0; i < cap.size() && i < 3; i++) begin
            checks++;
            if (cap[i].d !== 32'hCAFE_BABE + DW'(i) || cap[i].l !== (i == 2)) begin
                errors++;
                $display("FAIL sf_data%0d: got %h/%b want %h/%b", i,
                         cap[i].d, cap[i].l, 32'hCAFE_BABE + DW'(i), i == 2);
            end
        end
        checks++;
        if (sent0_cnt !== CW'(ce(1))) begin
            errors++;
            $display("FAIL sf_sent0: got %0d want %0d", sent0_cnt, ce(1));
        end
    endtask

    task automatic test_alternate();
        logic [DW-1:0] ed[8];
        logic [1:0]    eg[8];
        do_reset();
        channel_up = 1'b1;
        tx_tready  = 1'b1;
        push0(32'hA000_0000, 2, 4'hF);
        push0(32'hA000_0002, 2, 4'hF);
        push1(32'hB000_0000, 2, 4'hF);
        push1(32'hB000_0002, 2, 4'hF);
        ed = '{32'hA000_0000, 32'hA000_0001, 32'hB000_0000, 32'hB000_0001,
               32'hA000_0002, 32'hA000_0003, 32'hB000_0002, 32'hB000_0003};
        eg = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
        wait_cap(8, 60, "alt_beats");
        for (int i = 0; i < cap.size() && i < 8; i++) begin
            checks++;
            if (cap[i].d !== ed[i] || cap[i].g !== eg[i]) begin
                errors++;
                $display("FAIL alt_beat%0d: got %h g=%b want %h g=%b", i,
                         cap[i].d, cap[i].g, ed[i], eg[i]);
            end
            if (i > 0) begin
                checks++;
                if (cap[i].cyc - cap[i-1].cyc != ((i % 2 == 1) ? 1 : 2)) begin
                    errors++;
                    $display("FAIL alt_gap%0d: got %0d want %0d", i,
                             cap[i].cyc - cap[i-1].cyc, (i % 2 == 1) ? 1 : 2);
                end
            end
        end
        tick();
        checks++;
        if (sent0_cnt !== CW'(ce(2)) || sent1_cnt !== CW'(ce(2))) begin
            errors++;
            $display("FAIL alt_cnt: got %0d %0d want %0d %0d",
                     sent0_cnt, sent1_cnt, ce(2), ce(2));
        end
    endtask

    task automatic test_back_pressure();
        cap.delete();
        push1(32'hC000_0000, 4, 4'hF);
        tick();
        tick();
        for (int i = 0; i < 16 && cap.size() < 4; i++) begin
            tx_tready = (i % 2 == 0);
            #1;
            checks++;
            if (grant !== 2'b10 || s1_tready !== tx_tready || s0_tready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready%0d: g=%b s1=%b s0=%b want 10 %b 0",
                         i, grant, s1_tready, s0_tready, tx_tready);
            end
            tick();
        end
        tx_tready = 1'b1;
        checks++;
        if (cap.size() != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d want 4", cap.size());
        end
        for (int i = 0; i < cap.size() && i < 4; i++) begin
            checks++;
            if (cap[i].d !== 32'hC000_0000 + DW'(i)) begin
                errors++;
                $display("FAIL bp_data%0d: got %h want %h", i,
                         cap[i].d, 32'hC000_0000 + DW'(i));
            end
        end
        tick();
        checks++;
        if (sent1_cnt !== CW'(ce(3))) begin
            errors++;
            $display("FAIL bp_sent1: got %0d want %0d", sent1_cnt, ce(3));
        end
    endtask

    task automatic test_last_on_down();
        cap.delete();
        push0(32'hD00D_0001, 1, 4'b0011);
        tick();
        tick();
        channel_up = 1'b0;
        #1;
        checks++;
        if (tx_tvalid !== 1'b1 || tx_tkeep !== 4'b0011 || tx_tlast !== 1'b1 ||
            tx_data !== 32'hD00D_0001) begin
            errors++;
            $display("FAIL lod_beat: v=%b k=%b l=%b d=%h want 1 0011 1 d00d0001",
                     tx_tvalid, tx_tkeep, tx_tlast, tx_data);
        end
        tick();
        checks++;
        if (grant !== 2'b00 || frame_drop !== 1'b0 ||
            sent0_cnt !== CW'(ce(3)) || drop_cnt !== CW'(0)) begin
            errors++;
            $display("FAIL lod_after: g=%b fd=%b s0=%0d dc=%0d want 00 0 %0d 0",
                     grant, frame_drop, sent0_cnt, drop_cnt, ce(3));
        end
        channel_up = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        cap.delete();
        drops = 0;
        push0(32'hE000_0000, 5, 4'hF);
        for (int i = 0; i < 20 && cap.size() < 1; i++) tick();
        channel_up = 1'b0;
        tick();
        checks++;
        if (frame_drop !== 1'b1 || tx_tvalid !== 1'b0 || s0_tready !== 1'b1 ||
            cap.size() != 2) begin
            errors++;
            $display("FAIL fl_enter: fd=%b v=%b rdy=%b beats=%0d want 1 0 1 2",
                     frame_drop, tx_tvalid, s0_tready, cap.size());
        end
        tick();
        checks++;
        if (frame_drop !== 1'b0) begin
            errors++;
            $display("FAIL fl_pulse: fd=%b want 0", frame_drop);
        end
        for (int i = 0; i < 10 && q0.size() > 0; i++) tick();
        checks++;
        if (q0.size() != 0 || cap.size() != 2 || drops != 1 ||
            drop_cnt !== CW'(ce(1))) begin
            errors++;
            $display("FAIL fl_drain: left=%0d beats=%0d pulses=%0d dc=%0d want 0 2 1 %0d",
                     q0.size(), cap.size(), drops, drop_cnt, ce(1));
        end
        push1(32'hF000_0000, 2, 4'hF);
        repeat (3) begin
            tick();
            checks++;
            if (grant !== 2'b00 || s1_tready !== 1'b0) begin
                errors++;
                $display("FAIL fl_hold: g=%b rdy=%b want 00 0", grant, s1_tready);
            end
        end
        channel_up = 1'b1;
        wait_cap(4, 20, "fl_next");
        for (int i = 2; i < cap.size() && i < 4; i++) begin
            checks++;
            if (cap[i].d !== 32'hF000_0000 + DW'(i - 2) || cap[i].g !== 2'b10) begin
                errors++;
                $display("FAIL fl_s1beat%0d: got %h g=%b want %h g=10", i,
                         cap[i].d, cap[i].g, 32'hF000_0000 + DW'(i - 2));
            end
        end
        tick();
        checks++;
        if (sent1_cnt !== CW'(ce(4)) || sent0_cnt !== CW'(ce(3))) begin
            errors++;
            $display("FAIL fl_cnt: got %0d %0d want %0d %0d",
                     sent0_cnt, sent1_cnt, ce(3), ce(4));
        end
    endtask

    task automatic test_reset_mid();
        cap.delete();
        push0(32'h5000_0000, 3, 4'hF);
        for (int i = 0; i < 20 && cap.size() < 1; i++) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({grant, tx_tvalid, s0_tready, s1_tready, frame_drop} !== 6'b0 ||
            {sent0_cnt, sent1_cnt, drop_cnt} !== '0) begin
            errors++;
            $display("FAIL rm_async: outs=%b cnt=%h %h %h want 0",
                     {grant, tx_tvalid, s0_tready, s1_tready, frame_drop},
                     sent0_cnt, sent1_cnt, drop_cnt);
        end
        q0.delete();
        q1.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        cap.delete();
        push0(32'h6000_0000, 3, 4'hF);
        wait_cap(3, 20, "rm_beats");
        for (int i = 0; i < cap.size() && i < 3; i++) begin
            checks++;
            if (cap[i].d !== 32'h6000_0000 + DW'(i) || cap[i].g !== 2'b01) begin
                errors++;
                $display("FAIL rm_data%0d: got %h g=%b want %h g=01", i,
                         cap[i].d, cap[i].g, 32'h6000_0000 + DW'(i));
            end
        end
        tick();
        checks++;
        if (sent0_cnt !== CW'(ce(1)) || drop_cnt !== CW'(0)) begin
            errors++;
            $display("FAIL rm_cnt: got %0d %0d want %0d 0",
                     sent0_cnt, drop_cnt, ce(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        channel_up = 1'b0;
        tx_tready  = 1'b0;
        test_reset();
        test_single_frame();
        test_alternate();
        test_back_pressure();
        test_last_on_down();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aurora_tx_arbiter.md
AURORA_TX_ARBITER -- requirements
Module: aurora_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: stream data width in bits; KEEP_W = DATA_W/8.
REQ-002 SHALL have parameter CNT_W, default 16: width of statistics counters.
REQ-003 SHALL have port io_clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port channel_up, input, 1 bit: Aurora CHANNEL_UP, already synchronous to io_clk.
REQ-006 SHALL have ports s0_tdata (in, DATA_W), s0_tkeep (in, KEEP_W), s0_tlast (in, 1), s0_tvalid (in, 1), s0_tready (out, 1): requester 0 AXI-Stream.
REQ-007 SHALL have ports s1_tdata, s1_tkeep, s1_tlast, s1_tvalid, s1_tready, with the same widths and directions: requester 1 AXI-Stream.
REQ-008 SHALL have ports tx_data (out, DATA_W), tx_tkeep (out, KEEP_W), tx_tlast (out, 1), tx_tvalid (out, 1), tx_tready (in, 1): Aurora user TX stream.
REQ-009 SHALL have port grant, output, 2 bits: one-hot owner, 01 = s0, 10 = s1, 00 = none.
REQ-010 SHALL have port frame_drop, output, 1 bit: one-cycle pulse when a frame is aborted.
REQ-011 SHALL have ports sent0_cnt, sent1_cnt and drop_cnt, outputs, CNT_W each: statistics counters.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT0, GRANT1 and FLUSH, with a registered last_owner bit.
REQ-013 In IDLE, with channel_up=1 and any sN_tvalid=1, the FSM SHALL move next cycle to the GRANT state of the valid source; if both are valid, it SHALL grant the source not equal to last_owner.
REQ-014 In IDLE, the FSM SHALL drive tx_tvalid=0, s0_tready=0, s1_tready=0 and grant=00.
REQ-015 In GRANTn, the block SHALL drive tx_data, tx_tkeep, tx_tlast and tx_tvalid combinationally from sN, and drive sN_tready=tx_tready; the other source's tready SHALL be 0.
REQ-016 The block SHALL add zero data latency: a beat transfers on the cycle tx_tvalid & tx_tready.
REQ-017 A beat with tlast transferred in GRANTn SHALL return the FSM to IDLE next cycle and set last_owner=n; exactly one idle cycle separates frames.
REQ-018 The grant SHALL be frame-atomic: the FSM SHALL NOT switch owner before tlast, regardless of the other source's tvalid.
REQ-019 If channel_up=0 in GRANTn and the current beat is not a completing tlast beat, the FSM SHALL go to FLUSH and pulse frame_drop for one cycle.
REQ-020 In FLUSH, the block SHALL drive tx_tvalid=0 and sN_tready=1 for the aborted owner, discarding beats until a tlast beat; it SHALL then go to IDLE and set last_owner=n.
REQ-021 If channel_up=0 in GRANTn on the same cycle a tlast beat transfers, the frame SHALL count as sent and the FSM SHALL go to IDLE; no drop is recorded.
REQ-022 In IDLE with channel_up=0, no grant SHALL be issued and source tvalid SHALL be ignored.
REQ-023 The counters SHALL increment on a completed frame per source (sent0_cnt, sent1_cnt) and on entry to FLUSH (drop_cnt); they SHALL wrap modulo 2^CNT_W.
REQ-024 A tlast with tkeep not all-ones SHALL be forwarded unmodified.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state IDLE, last_owner=1 (s0 wins the first contention), grant=00, frame_drop=0, all counters 0, tx_tvalid=0 and both treadys 0.
REQ-026 A reset asserted mid-frame SHALL abandon the frame with no flush; after release, the FSM SHALL start in IDLE.
REQ-027 reset_n release SHALL be synchronized externally; the block SHALL NOT add a synchronizer.

Configuration
REQ-028 With macro TX_ARB_STATS_EN defined, the block SHALL implement sent0_cnt, sent1_cnt and drop_cnt per REQ-023.
REQ-029 Without TX_ARB_STATS_EN, those ports SHALL remain present and be tied to 0, with no counter flops; frame_drop is unaffected.

Verification
REQ-030 Reset, then channel_up=1 and s0 sends 3 beats 0xCAFEBABE..+2 with tlast on beat 3 and tready=1 -> grant=01 one cycle after tvalid, 3 beats on tx_data, IDLE after; sent0_cnt=1.
REQ-031 s0 and s1 both hold valid 2-beat frames continuously -> frames alternate s0,s1,s0,s1 with one idle cycle between frames and no interleaved beats.
REQ-032 tx_tready toggles 1,0,1,0 during an s1 frame -> s1_tready mirrors it, every beat is transferred exactly once, and order is preserved.
REQ-033 channel_up drops after beat 2 of a 5-beat s0 frame -> frame_drop pulses once, beats 3-5 are consumed with tx_tvalid=0, drop_cnt=1, and the next s1 frame is granted after channel_up returns.
REQ-034 reset_n asserted mid-frame -> all outputs reach reset values immediately, grant=00; after release, a new s0 frame is forwarded correctly.
REQ-035 Build without TX_ARB_STATS_EN and run REQ-030 -> counters read 0 and forwarding is identical.
